taylor_trig_param: RTL and testbench

Parametrised fixed-point Taylor-series evaluator for cos or sin. It runs Horner's scheme on x² with one shared signed multiplier and sits in the same datapath slot as the earlier 25-bit cosine core. It extends that core with configurable word and fraction width, a configurable term count, a run-time cos/sin mode select, a busy flag and output saturation. The start/ready handshake matches the earlier core, so existing sweep benches drive it unchanged.

---
 rtl/taylor_trig_param.sv | 162 ++++++++++++++++
 tb/tb_taylor_trig_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/taylor_trig_param.sv
// Fixed-point cos/sin evaluator using Horner's scheme on x^2.
// A single signed multiplier is shared between the squaring, Horner and final-x steps.
// acc and x2 carry two guard bits above W. The result is saturated only at the output.
module taylor_trig_param #(
  parameter int W     = 25,
  parameter int FRAC  = 23,
  parameter int TERMS = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         mode_in,
  input  logic [W-1:0] angle_in,
  output logic         ready_out,
  output logic         busy_out,
  output logic [W-1:0] result_out
);

  localparam int AW = W + 2;
  localparam int PW = 2 * AW;
  localparam int KW = $clog2(TERMS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ,
    S_HORN,
    S_MULX,
    S_DONE
  } state_t;

  // Compute round(+-2^FRAC / n!), with n = 2k (cos) or n = 2k+1 (sin).
  // The sign alternates with k.
  function automatic logic signed [AW-1:0] coef(input int unsigned k, input logic sin_m);
    longint      fact;
    longint      mag;
    int unsigned n;
    n    = 2 * k + {31'd0, sin_m};
    fact = 1;
    for (int unsigned i = 2; i <= n; i++) begin
      fact = fact * longint'(i);
    end
    mag = ((longint'(1) <<< FRAC) + fact / 2) / fact;
    if (k % 2 == 1) begin
      mag = -mag;
    end
    return AW'(mag);
  endfunction

  logic signed [AW-1:0] cos_c [TERMS];
  logic signed [AW-1:0] sin_c [TERMS];

  for (genvar g = 0; g < TERMS; g++) begin : g_coef
    assign cos_c[g] = coef(g, 1'b0);
    assign sin_c[g] = coef(g, 1'b1);
  end

  state_t               state;
  state_t               nxt;
  logic                 mode;
  logic        [KW-1:0] k;
  logic signed [AW-1:0] x;
  logic signed [AW-1:0] x2;
  logic signed [AW-1:0] acc;

  logic signed [AW-1:0] mul_a;
  logic signed [AW-1:0] mul_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] scaled;
  logic signed [AW-1:0] c_k;
  logic        [W-1:0]  sat;
  logic                 accept;
  logic                 busy_nxt;
  logic                 ready_nxt;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = S_SQ;
      S_SQ:   nxt = S_HORN;
      S_HORN: if (k == '0) nxt = mode ? S_MULX : S_DONE;
      S_MULX: nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Output decode: handshake next values, multiplier operand routing, coefficient pick, output clamp.
  always_comb begin
    accept    = (state == S_IDLE) && start;
    // busy stays high through the ready cycle (spent in IDLE) and only drops if no new start arrives there.
    busy_nxt  = (state != S_IDLE) || accept;
    ready_nxt = (state == S_DONE);
    mul_a     = acc;
    mul_b     = x2;
    case (state)
      S_SQ: begin
        mul_a = x;
        mul_b = x;
      end
      S_MULX: mul_b = x;
      default: ;
    endcase
    prod   = {{AW{mul_a[AW-1]}}, mul_a} * {{AW{mul_b[AW-1]}}, mul_b};
    scaled = AW'(prod >>> FRAC);
    c_k    = mode ? sin_c[k] : cos_c[k];
    if (acc[AW-1:W-1] == '0 || acc[AW-1:W-1] == '1) begin
      sat = acc[W-1:0];
    end else if (acc[AW-1]) begin
      sat = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(W-1){1'b1}}};
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_out  <= 1'b0;
      busy_out   <= 1'b0;
      result_out <= '0;
      mode       <= 1'b0;
      k          <= '0;
      x          <= '0;
      x2         <= '0;
      acc        <= '0;
    end else begin
      ready_out <= ready_nxt;
      busy_out  <= busy_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            x    <= {{2{angle_in[W-1]}}, angle_in};
            mode <= mode_in;
            acc  <= mode_in ? sin_c[TERMS-1] : cos_c[TERMS-1];
          end
        end
        S_SQ: begin
          x2 <= scaled;
          k  <= KW'(TERMS - 2);
        end
        S_HORN: begin
          acc <= c_k + scaled;
          if (k != '0) k <= k - 1'b1;
        end
        S_MULX: acc <= scaled;
        S_DONE: result_out <= sat;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_taylor_trig_param.sv
// Directed bench for taylor_trig_param (W=25, FRAC=23): TERMS=5 main instance plus a TERMS=8 instance.
module tb_taylor_trig_param;

  localparam int W = 25;
  localparam int HALF_PI = 13176795;
  localparam real ONE = 8388608.0;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode_in;
  logic [W-1:0] angle_in;
  logic         ready_out, busy_out;
  logic [W-1:0] result_out;
  logic         ready8, busy8;
  logic [W-1:0] result8;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_cnt = 0;
  int r8_cnt = 0;
  longint r8_last = 0;

  taylor_trig_param #(.W(W), .FRAC(23), .TERMS(5)) u_dut (
    .clock(clk), .reset(rst), .start(start), .mode_in(mode_in), .angle_in(angle_in),
    .ready_out(ready_out), .busy_out(busy_out), .result_out(result_out)
  );

  taylor_trig_param #(.W(W), .FRAC(23), .TERMS(8)) u_dut8 (
    .clock(clk), .reset(rst), .start(start), .mode_in(mode_in), .angle_in(angle_in),
    .ready_out(ready8), .busy_out(busy8), .result_out(result8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready_out) ready_cnt++;
    if (ready8) begin
      r8_cnt++;
      r8_last = longint'($signed(result8));
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    n_tests++;
    if (obs - exp > tol || exp - obs > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Launch one operation; optionally fire a second start two cycles in.
  // cyc is the number of edges after the accepting edge at which ready_out is seen.
  task automatic run_op(input bit md, input int ang, input bit interfere,
                        output longint res, output int cyc, output bit got, output bit busy_ok);
    @(negedge clk);
    start    = 1'b1;
    mode_in  = md;
    angle_in = W'(ang);
    @(posedge clk);
    got = 1'b0; cyc = -1; busy_ok = 1'b1; res = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start = interfere && (i == 1);
      if (interfere && i == 1) begin
        mode_in  = 1'b1;
        angle_in = W'(4000000);
      end
      if (!busy_out) busy_ok = 1'b0;
      if (ready_out) begin
        got = 1'b1;
        cyc = i;
        res = longint'($signed(result_out));
      end
    end
    start = 1'b0;
  endtask

  longint res;
  int     cyc, c0, c8, ops, tmo, first_rdy, second_rdy;
  bit     got, bok;
  real    ref_v, err, max_c, max_s, sum_c, sum_s;
  int     n_c, n_s;

  initial begin
    rst = 1'b1; start = 1'b0; mode_in = 1'b0; angle_in = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready_out, 0, 0);
    check("rst_busy", busy_out, 0, 0);
    check("rst_result", result_out, 0, 0);
    rst = 1'b0;

    c0 = ready_cnt;
    run_op(1'b0, 8192, 1'b0, res, cyc, got, bok);
    check("cos8192_got", got, 1, 0);
    check("cos8192_res", res, 8388604, 0);
    check("cos8192_lat", cyc, 6, 0);
    check("cos8192_busy", bok, 1, 0);
    @(negedge clk);
    check("cos8192_nrdy", ready_cnt - c0, 1, 0);

    run_op(1'b0, 0, 1'b0, res, cyc, got, bok);
    check("cos0_res", res, 8388608, 0);
    check("cos0_lat", cyc, 6, 0);

    run_op(1'b1, 0, 1'b0, res, cyc, got, bok);
    check("sin0_got", got, 1, 0);
    check("sin0_res", res, 0, 0);
    check("sin0_lat", cyc, 7, 0);

    run_op(1'b1, 8388608, 1'b0, res, cyc, got, bok);
    check("sin1_res", res, 7058771, 0);
    check("sin1_tol", res, 7058770, 8);

    run_op(1'b0, 8388608, 1'b0, res, cyc, got, bok);
    check("cos1_res", res, 4532386, 0);

    // Second start two cycles in must be ignored.
    repeat (15) @(negedge clk);
    c0 = ready_cnt;
    run_op(1'b0, 8388608, 1'b1, res, cyc, got, bok);
    check("ign_res", res, 4532386, 0);
    check("ign_lat", cyc, 6, 0);
    check("ign_busy", bok, 1, 0);
    repeat (12) @(negedge clk);
    check("ign_nrdy", ready_cnt - c0, 1, 0);

    // pi/2 on both term counts.
    repeat (15) @(negedge clk);
    c8 = r8_cnt;
    run_op(1'b0, HALF_PI, 1'b0, res, cyc, got, bok);
    check("cos_pi2_t5", res, 0, 256);
    repeat (12) @(negedge clk);
    check("cos_pi2_t8_nrdy", r8_cnt - c8, 1, 0);
    check("cos_pi2_t8", r8_last, 0, 16);

    // start held high: back-to-back cos at TERMS+2 cycle spacing.
    repeat (15) @(negedge clk);
    start = 1'b1; mode_in = 1'b0; angle_in = '0;
    first_rdy = -1; second_rdy = -1; bok = 1'b1;
    for (int i = 0; i < 40 && second_rdy < 0; i++) begin
      @(negedge clk);
      if (i > 0 && !busy_out) bok = 1'b0;
      if (ready_out) begin
        if (first_rdy < 0) first_rdy = i;
        else second_rdy = i;
      end
    end
    start = 1'b0;
    check("b2b_spacing", second_rdy - first_rdy, 7, 0);
    check("b2b_busy", bok, 1, 0);

    // Asynchronous reset mid-operation.
    repeat (15) @(negedge clk);
    check("pre_rst_result_nz", (result_out != '0), 1, 0);
    @(negedge clk);
    start = 1'b1; mode_in = 1'b0; angle_in = W'(8388608);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    c0 = ready_cnt;
    check("arst_ready", ready_out, 0, 0);
    check("arst_busy", busy_out, 0, 0);
    check("arst_result", result_out, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_no_ready", ready_cnt - c0, 0, 0);
    check("arst_busy_after", busy_out, 0, 0);

    // Sweep both modes against a real-valued model.
    max_c = 0.0; max_s = 0.0; sum_c = 0.0; sum_s = 0.0; n_c = 0; n_s = 0;
    ops = 0; tmo = 0;
    c0 = ready_cnt;
    for (int md = 0; md < 2; md++) begin
      for (int a = 8192; a <= HALF_PI; a += 8192) begin
        run_op(md[0], a, 1'b0, res, cyc, got, bok);
        ops++;
        if (!got) tmo++;
        ref_v = (md == 1) ? $sin(a / ONE) * ONE : $cos(a / ONE) * ONE;
        err = real'(res) - ref_v;
        if (md == 1) begin
          sum_s += err; n_s++;
          if (err < 0.0) err = -err;
          if (err > max_s) max_s = err;
        end else begin
          sum_c += err; n_c++;
          if (err < 0.0) err = -err;
          if (err > max_c) max_c = err;
        end
      end
    end
    @(negedge clk);
    check("sweep_timeouts", tmo, 0, 0);
    check("sweep_nrdy", ready_cnt - c0, ops, 0);
    check("sweep_cos_maxerr", longint'($ceil(max_c)), 0, 256);
    check("sweep_sin_maxerr", longint'($ceil(max_s)), 0, 256);
    $display("[TB] sweep mean error: cos %f LSB, sin %f LSB", sum_c / n_c, sum_s / n_s);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
